// File: rtl/hdmi_disp_seq.sv
// Power-up and test-pattern sequencer for the HDMI TX path (reference-clock domain).
// Drives the PLL reset, waits for lock with timeout/retry, gates the display,
// steps the TPG mode (auto dwell or debounced push-button) and drives a heartbeat LED.
module hdmi_disp_seq #(
  parameter int unsigned MODE_W         = 4,
  parameter int unsigned MODE_MIN       = 1,
  parameter int unsigned MODE_MAX       = 11,
  parameter int unsigned DWELL_LOG2     = 26,
  parameter int unsigned PLL_RST_CYCLES = 128,
  parameter int unsigned LOCK_TO_LOG2   = 20,
  parameter int unsigned DEB_LOG2       = 16,
  parameter int unsigned LED_LOG2       = 24
) (
  input  logic              CLK_I,
  input  logic              RST_N_I,
  input  logic              DISPLAY_ON_I,
  input  logic              LOCKED_I,
  input  logic              AUTO_I,
  input  logic              STEP_I,
  output logic              PLL_RST_O,
  output logic              DEN_O,
  output logic              DISP_RST_O,
  output logic [MODE_W-1:0] MODE_O,
  output logic              MODE_STB_O,
  output logic              LED_O,
  output logic [1:0]        STATE_O
);

  typedef enum logic [1:0] {
    S_OFF       = 2'd0,
    S_PLL_RST   = 2'd1,
    S_WAIT_LOCK = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  // One shared cycle counter covers both the PLL reset pulse and the lock timeout.
  localparam int unsigned PLL_W = $clog2(PLL_RST_CYCLES + 1);
  localparam int unsigned CNT_W = (PLL_W > LOCK_TO_LOG2) ? PLL_W : LOCK_TO_LOG2;
  localparam logic [CNT_W-1:0]  PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'((64'd1 << LOCK_TO_LOG2) - 64'd1);
  localparam logic [MODE_W-1:0] MODE_LO   = MODE_W'(MODE_MIN);
  localparam logic [MODE_W-1:0] MODE_HI   = MODE_W'(MODE_MAX);

  logic on_meta_q, on_s_q;
  logic lock_meta_q, lock_s_q;
  logic step_meta_q, step_s_q;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DWELL_LOG2-1:0] dwell_q, dwell_d;
  logic [DEB_LOG2-1:0]   deb_cnt_q, deb_cnt_d;
  logic                  step_acc_q, step_acc_d;
  logic [LED_LOG2-1:0]   led_cnt_q, led_cnt_d;
  logic [MODE_W-1:0]     mode_q, mode_d;
  logic                  pll_rst_q, den_q, disp_rst_q, mode_stb_q;
  logic                  step_evt, advance;

  // Two-flop synchronisers for the asynchronous level inputs.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      on_meta_q   <= 1'b0;
      on_s_q      <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      step_meta_q <= 1'b0;
      step_s_q    <= 1'b0;
    end else begin
      on_meta_q   <= DISPLAY_ON_I;
      on_s_q      <= on_meta_q;
      lock_meta_q <= LOCKED_I;
      lock_s_q    <= lock_meta_q;
      step_meta_q <= STEP_I;
      step_s_q    <= step_meta_q;
    end
  end

  // Next-state, counters, debounce, heartbeat and mode stepping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dwell_d    = dwell_q;
    deb_cnt_d  = deb_cnt_q;
    step_acc_d = step_acc_q;
    led_cnt_d  = '0;
    mode_d     = mode_q;
    step_evt   = 1'b0;
    advance    = 1'b0;

    // Debounce: count while the synchronised button disagrees with the accepted level.
    if (step_s_q == step_acc_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == '1) begin
      deb_cnt_d  = '0;
      step_acc_d = step_s_q;
      step_evt   = step_s_q;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_LOG2'(1);
    end

    // Heartbeat runs only while locked and powered up.
    if (lock_s_q && (state_q != S_OFF)) begin
      led_cnt_d = led_cnt_q + LED_LOG2'(1);
    end

    case (state_q)
      S_OFF: begin
        cnt_d = '0;
        if (on_s_q) state_d = S_PLL_RST;
      end
      S_PLL_RST: begin
        if (cnt_q == PLL_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          mode_d  = MODE_LO;
        end else begin
          dwell_d = AUTO_I ? (dwell_q + DWELL_LOG2'(1)) : '0;
          // A coincident step edge and dwell wrap still yield a single advance.
          advance = step_evt || (AUTO_I && (dwell_q == '1));
          if (step_evt) dwell_d = '0;
          if (advance) mode_d = (mode_q == MODE_HI) ? MODE_LO : (mode_q + MODE_W'(1));
        end
      end
      default: state_d = S_OFF;
    endcase

    // Dropping the display request overrides everything and freezes the mode.
    if (!on_s_q) begin
      state_d = S_OFF;
      cnt_d   = '0;
      mode_d  = mode_q;
    end

    // Dwell restarts from zero on every entry to RUN.
    if (state_d != S_RUN) dwell_d = '0;
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      dwell_q    <= '0;
      deb_cnt_q  <= '0;
      step_acc_q <= 1'b0;
      led_cnt_q  <= '0;
      mode_q     <= MODE_LO;
      pll_rst_q  <= 1'b1;
      den_q      <= 1'b0;
      disp_rst_q <= 1'b1;
      mode_stb_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dwell_q    <= dwell_d;
      deb_cnt_q  <= deb_cnt_d;
      step_acc_q <= step_acc_d;
      led_cnt_q  <= led_cnt_d;
      mode_q     <= mode_d;
      pll_rst_q  <= (state_d == S_OFF) || (state_d == S_PLL_RST);
      den_q      <= (state_d == S_RUN);
      disp_rst_q <= (state_d != S_RUN);
      mode_stb_q <= (mode_d != mode_q);
    end
  end

  assign PLL_RST_O  = pll_rst_q;
  assign DEN_O      = den_q;
  assign DISP_RST_O = disp_rst_q;
  assign MODE_O     = mode_q;
  assign MODE_STB_O = mode_stb_q;
  assign LED_O      = led_cnt_q[LED_LOG2-1];
  assign STATE_O    = state_q;

endmodule
